// File: rtl/fetch_ctrl_pkg.sv
// Shared stage1 definitions: fetch FSM state encoding and counter saturation helpers.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RESP  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_e;

    localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_SAT) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction buffer that parks a fetched word while the next stage is stalled.
module fetch_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] din,
    output logic        valid,
    output logic [31:0] data
);

    // Clear wins over load: a redirect must never leave a stale word behind.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Stage1 fetch controller: one outstanding imem request, redirect handling and PC hold/select.
// Handshakes: a transfer occurs on a rising edge where valid and ready are both high.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic        stage_stall,
    output logic        stall,
    output logic        PC_Sel,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic        flush,
    output logic [31:0] bubble_cnt,
    output logic [2:0]  state_dbg
);

    fetch_state_e state;

    logic        buf_valid;
    logic [31:0] buf_data;
    logic        buf_load;
    logic        buf_clear;
    logic        active;
    logic        redirect_cycle;
    logic        deliver_resp;
    logic        deliver_buf;
    logic        advance;

    // Outputs are gated by reset so an interrupted request goes quiet immediately.
    assign active         = reset && (state != IDLE);
    assign redirect_cycle = active && redirect_valid;
    assign deliver_resp   = active && !redirect_valid && (state == RESP) && imem_resp_valid;
    assign deliver_buf    = active && !redirect_valid && (state == HOLD) && buf_valid;
    assign advance        = inst_valid && !stage_stall;

    assign inst_valid     = deliver_resp || deliver_buf;
    assign inst           = deliver_buf  ? buf_data :
                            deliver_resp ? imem_rdata : 32'd0;
    assign stall          = !(advance || redirect_cycle);
    assign PC_Sel         = redirect_cycle;
    assign flush          = redirect_cycle;
    assign imem_req_valid = reset && (state == REQ);
    assign state_dbg      = state;

    assign buf_load  = deliver_resp && stage_stall;
    assign buf_clear = reset && (state == HOLD) && (redirect_valid || !stage_stall);

    fetch_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (imem_rdata),
        .valid (buf_valid),
        .data  (buf_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            bubble_cnt <= '0;
        end else begin
            if ((state != IDLE) && !inst_valid)
                bubble_cnt <= sat_inc(bubble_cnt);

            case (state)
                IDLE: state <= REQ;
                // A redirect accepted with the request leaves a stale response in flight.
                REQ: begin
                    if (imem_req_ready)
                        state <= redirect_valid ? DRAIN : RESP;
                end
                RESP: begin
                    if (redirect_valid)
                        state <= imem_resp_valid ? REQ : DRAIN;
                    else if (imem_resp_valid)
                        state <= stage_stall ? HOLD : REQ;
                end
                HOLD: begin
                    if (redirect_valid || !stage_stall)
                        state <= REQ;
                end
                DRAIN: begin
                    if (imem_resp_valid)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected instructions are queued by the stimulus and checked by a monitor.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic        stage_stall;
    logic        stall;
    logic        PC_Sel;
    logic        inst_valid;
    logic [31:0] inst;
    logic        flush;
    logic [31:0] bubble_cnt;
    logic [2:0]  state_dbg;

    logic [31:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    fetch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .stage_stall     (stage_stall),
        .stall           (stall),
        .PC_Sel          (PC_Sel),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .flush           (flush),
        .bubble_cnt      (bubble_cnt),
        .state_dbg       (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // driver tasks
    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic redir, input logic ss);
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_rdata      = rd;
        redirect_valid  = redir;
        stage_stall     = ss;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (inst_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_inst: got 0x%08h expected no instruction at %0t", inst, $time);
            end else begin
                check("inst", inst, exp_q.pop_front());
            end
        end
        if (flush === 1'b1) check("valid_flush_excl", {31'd0, inst_valid}, 32'd0);
    end

    initial begin
        reset = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; stage_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("rst_state", {29'd0, state_dbg}, {29'd0, IDLE});
        check("rst_outs", {26'd0, stall, PC_Sel, imem_req_valid, inst_valid, flush, 1'b0}, 32'h20);
        check("rst_inst", inst, 32'd0);
        check("rst_bubble", bubble_cnt, 32'd0);

        // Release reset; redirect in IDLE must be ignored.
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("idle_redirect_ignored", {30'd0, flush, PC_Sel}, 32'd0);
        check("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
        step();
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        check("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
        step();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("c2_resp_wait", {30'd0, stall, inst_valid}, 32'h2);
        step();
        exp_q.push_back(32'h0000_0013);
        drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
        check("c3_advance", {29'd0, inst_valid, stall, PC_Sel}, 32'h4);
        check("c3_bubble", bubble_cnt, 32'd2);
        step();

        // Stalled delivery parks the word in HOLD for four cycles.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        exp_q.push_back(32'hDEAD_BEEF);
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        check("resp_stalled", {30'd0, inst_valid, stall}, 32'h3);
        step();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'hDEAD_BEEF);
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            check("hold_state", {29'd0, state_dbg}, {29'd0, HOLD});
            check("hold_stall", {31'd0, stall}, 32'd1);
            step();
        end
        exp_q.push_back(32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("hold_release", {30'd0, stall, PC_Sel}, 32'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("after_hold_req", {29'd0, state_dbg}, {29'd0, REQ});
        check("hold_bubble", bubble_cnt, 32'd3);

        // Redirect in RESP before the response arrives.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("resp_redirect", {28'd0, flush, PC_Sel, stall, inst_valid}, 32'hC);
        step();
        drive(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
        check("drain_state", {29'd0, state_dbg}, {29'd0, DRAIN});
        check("drain_no_inst", {31'd0, inst_valid}, 32'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("drain_to_req", {31'd0, imem_req_valid}, 32'd1);

        // Redirect while REQ is not yet accepted keeps requesting.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("req_redirect", {29'd0, flush, PC_Sel, stall}, 32'h6);
        step();
        // Redirect coinciding with acceptance sends the response to DRAIN.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check("req_still", {29'd0, state_dbg}, {29'd0, REQ});
        check("req_ready_redirect", {30'd0, flush, PC_Sel}, 32'h3);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("drain2_state", {29'd0, state_dbg}, {29'd0, DRAIN});
        check("drain_redirect", {30'd0, PC_Sel, stall}, 32'h2);
        step();
        drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0);
        check("drain_stays", {29'd0, state_dbg}, {29'd0, DRAIN});
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("drain2_to_req", {29'd0, state_dbg}, {29'd0, REQ});

        // Redirect while holding drops the buffered word.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        exp_q.push_back(32'hCAFE_F00D);
        drive(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("hold_redirect", {29'd0, flush, inst_valid, stall}, 32'h4);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("hold_redirect_req", {29'd0, state_dbg}, {29'd0, REQ});

        // Reset in RESP followed by a late response.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0);
        check("late_resp_state", {29'd0, state_dbg}, {29'd0, IDLE});
        check("late_resp_valid", {31'd0, inst_valid}, 32'd0);
        check("late_resp_bubble", bubble_cnt, 32'd0);
        step();
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0);
        check("late_resp_req", {30'd0, imem_req_valid, inst_valid}, 32'h2);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        exp_q.push_back(32'h0000_0077);
        drive(1'b0, 1'b1, 32'h0000_0077, 1'b0, 1'b0);
        step();

        // Counter saturation.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        force dut.bubble_cnt = 32'hFFFF_FFFE;
        step();
        release dut.bubble_cnt;
        repeat (3) step();
        check("bubble_sat", bubble_cnt, 32'hFFFF_FFFF);
        step();
        check("bubble_sat_hold", bubble_cnt, 32'hFFFF_FFFF);

        step();
        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, single clock, all state on rising edge.
REQ-002 SHALL have ports: reset in 1, synchronous, active-low.
REQ-003 SHALL have ports: imem_req_valid out 1; imem_req_ready in 1; imem_resp_valid in 1; imem_rdata in 32, instruction memory fetch handshake at address PC_Out.
REQ-004 SHALL have ports: redirect_valid in 1, taken branch/jump from stage2, target on ALU_Out.
REQ-005 SHALL have ports: stage_stall in 1, downstream cannot accept an instruction this cycle.
REQ-006 SHALL have ports: stall out 1, PC register hold; PC_Sel out 1, 1 selects ALU_Out, 0 selects PC+4.
REQ-007 SHALL have ports: inst_valid out 1; inst out 32; flush out 1, kill stage1 contents; bubble_cnt out 32.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, RESP, HOLD, DRAIN, with at most one outstanding memory request.
REQ-009 SHALL drive imem_req_valid=1 only in REQ.
REQ-010 SHALL drive stall=1 in every cycle except a PC-advance cycle (REQ-011) or a redirect cycle (REQ-012).
REQ-011 SHALL produce a PC-advance cycle (stall=0, PC_Sel=0) when inst_valid=1, stage_stall=0 and redirect_valid=0.
REQ-012 SHALL produce a redirect cycle (stall=0, PC_Sel=1, flush=1, inst_valid=0) whenever redirect_valid=1 in any state except IDLE; redirect has priority over every other event.
REQ-013 SHALL, in IDLE, go to REQ on the first cycle after reset deasserts, ignoring redirect_valid.
REQ-014 SHALL, in REQ, go to RESP on imem_req_ready=1 without redirect, go to DRAIN on imem_req_ready=1 with redirect, and otherwise stay in REQ; the address may change only on a redirect cycle.
REQ-015 SHALL, in RESP with imem_resp_valid=1 and no redirect, present inst=imem_rdata with inst_valid=1 in the same cycle, combinationally.
REQ-016 SHALL, on that RESP delivery, go to REQ if stage_stall=0, or capture imem_rdata into the one-entry buffer and go to HOLD if stage_stall=1.
REQ-017 SHALL, in RESP with redirect, go to REQ if imem_resp_valid=1 (response discarded), else go to DRAIN.
REQ-018 SHALL, in HOLD, present the buffered instruction with inst_valid=1, and go to REQ when stage_stall=0; a redirect discards the buffer and goes to REQ.
REQ-019 SHALL, in DRAIN, hold inst_valid=0, discard the response on imem_resp_valid=1 and go to REQ; a further redirect in DRAIN updates the PC and stays in DRAIN, unless imem_resp_valid=1 in that cycle, which goes to REQ.
REQ-020 SHALL increment bubble_cnt each non-IDLE cycle with inst_valid=0, saturating at 0xFFFFFFFF.
REQ-021 SHALL never assert inst_valid and flush in the same cycle.

Reset
REQ-022 SHALL, on the rising edge of clk with reset=0, set state=IDLE, clear the buffer valid flag, and set bubble_cnt=0.
REQ-023 SHALL drive, while reset=0 and in IDLE: stall=1, PC_Sel=0, imem_req_valid=0, inst_valid=0, flush=0, inst=0.
REQ-024 SHALL, when reset asserts mid-operation, abandon any outstanding request, and ignore any late imem_resp_valid until the next REQ handshake completes.

Structure
REQ-025 SHALL take the FSM state enum and the 32-bit counter saturation constant from the shared stage1 package.
REQ-026 SHALL place the one-entry instruction buffer (data, valid, load/clear) in sub-module fetch_buf.
REQ-027 SHALL use combinational outputs for stall, PC_Sel and flush, decoded from state and current-cycle inputs.

Verification
REQ-028 SHALL cover: reset held 3 cycles then released, ready=1, resp one cycle later with rdata=0x00000013 -> imem_req_valid in cycle 1; inst_valid=1, inst=0x13, stall=0, PC_Sel=0 in cycle 3.
REQ-029 SHALL cover: resp 0xDEADBEEF with stage_stall=1 for 4 cycles -> HOLD, inst=0xDEADBEEF held 4 cycles, stall=1, then one PC-advance cycle.
REQ-030 SHALL cover: redirect in RESP before resp, then resp 0x11111111 -> flush=1, PC_Sel=1 in redirect cycle; DRAIN; 0x11111111 never on inst_valid; next REQ at target.
REQ-031 SHALL cover: redirect in the same cycle as imem_req_ready=1 -> DRAIN, stale response dropped.
REQ-032 SHALL cover: reset asserted in RESP, then a late imem_resp_valid -> inst_valid stays 0 and bubble_cnt=0.
REQ-033 SHALL cover: bubble_cnt forced to 0xFFFFFFFE, then 3 bubble cycles -> bubble_cnt=0xFFFFFFFF.
